mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-into-one arbiter on the `mem_bus` protocol. It sits directly downstream of `n64_pi`, whose `mem_bus.controller` port becomes requester 0, and of the MCU/USB path, which becomes requester 1. The arbiter owns the single `mem_bus.controller` port into the SDRAM/flash memory backend. It serialises 16-bit read/write transactions, gives N64 priority with a bounded CPU starvation limit, and tolerates requesters that abandon a request mid-flight.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive N64 grants allowed while a CPU request is pending. Range 1–15.

Ports:
- `clk` input 1: single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `n64_bus` mem_bus.memory: requester 0.
  - In: request, write, address[31:0], wdata[15:0], wmask[1:0].
  - Out: ack, rdata[15:0].
- `cpu_bus` mem_bus.memory: requester 1, same signals as `n64_bus`.
- `mem_bus` mem_bus.controller: to the memory backend.
  - Out: request, write, address[31:0], wdata[15:0], wmask[1:0].
  - In: ack, rdata[15:0].
- `busy` output 1: high while state ≠ IDLE, for debug/status.

## Operation
- States (`e_arb_state`): IDLE, GRANT_N64, GRANT_CPU.
- IDLE transitions:
  - Only one requester requesting → grant it.
  - Both requesting → grant N64 if `starve_cnt < STARVE_LIMIT`, otherwise grant CPU.
  - Neither requesting → stay in IDLE.
- On entering a GRANT state, latch from the winner into the `mem_bus` output registers:
  - write, address, wdata, wmask.
  - Set `mem_bus.request`.
- Held values: all `mem_bus` outputs stay constant until `mem_bus.ack`.
- Ack routing:
  - `mem_bus.ack` is forwarded combinationally to the granted requester's ack only (`n64_bus.ack` or `cpu_bus.ack`).
  - The non-granted requester's ack is always 0.
- rdata: `mem_bus.rdata` is passed combinationally to both requesters' rdata. Requesters sample it only on their own ack.
- After ack: the edge following `mem_bus.ack` clears `mem_bus.request` and returns the state to IDLE.
- `starve_cnt` (4-bit, saturating):
  - Increments on each N64 grant taken while `cpu_bus.request` is high.
  - Clears on any CPU grant, and whenever `cpu_bus.request` is low in IDLE.
- Abandoned request: the granted requester may drop request before ack (`n64_pi` does this on N64 reset).
  - The arbiter sets an internal `drop` flag.
  - It keeps `mem_bus.request` asserted until `mem_bus.ack`.
  - It suppresses forwarding of that ack (requester ack stays 0).
  - It then returns to IDLE.
  - `drop` clears on return to IDLE.
- Requester request pulses that arrive while the other requester is granted are not queued. Each requester holds request high until its own ack; the arbiter re-samples in IDLE.
- Address and data pass through unmodified. No width conversion, no address translation.

## Timing
- Reset values (async):
  - state = IDLE.
  - `mem_bus.request` = 0, `mem_bus.write` = 0, `mem_bus.address` = 0, `mem_bus.wdata` = 0, `mem_bus.wmask` = 0.
  - `starve_cnt` = 0, `drop` = 0, `busy` = 0.
  - Both requester acks = 0.
- Reset mid-transaction: all of the above are cleared immediately. A pending backend ack after reset deassertion is ignored because state is IDLE.
- Grant latency: a request high at cycle N in IDLE produces `mem_bus.request` = 1 at cycle N+1.
- Ack path: zero cycles. Backend ack at cycle M gives requester ack at cycle M.
- Release: `mem_bus.request` = 0 and state = IDLE at M+1. The earliest next grant is at M+2.
- Minimum spacing: two back-to-back transactions from the same requester are separated by one idle cycle of `mem_bus.request`.
- Simultaneous events:
  - Both requests rising in the same IDLE cycle resolve by the starvation rule.
  - A requester dropping request in the same cycle as ack counts as a normal completion; the ack is forwarded.

## Structure
- Package `mem_bus_arbiter_pkg`:
  - `e_arb_state` enum.
  - `STARVE_CNT_W` = 4 constant.
- Single module. No sub-module is warranted: the output register bank and FSM are one always_ff block, and ack/rdata routing is one always_comb block.

## Test plan
- N64 read at address 0x0000_1000; backend acks 3 cycles after request.
  - `mem_bus` address = 0x1000, write = 0.
  - `n64_bus.ack` fires in the ack cycle with rdata = 0xBEEF.
  - `cpu_bus.ack` is never 1.
- N64 and CPU request continuously, STARVE_LIMIT = 4.
  - Grant order is N64, N64, N64, N64, CPU, repeating.
  - No requester ever sees the other's ack.
- CPU write of 0x1234 at address 0x0500_0002, wmask 2'b11, while N64 is idle.
  - `mem_bus` carries exactly these values, held constant until ack.
  - `busy` falls one cycle after ack.
- N64 drops request 1 cycle after grant; backend acks 5 cycles later.
  - `mem_bus.request` stays high until ack.
  - `n64_bus.ack` stays 0.
  - The arbiter is in IDLE the cycle after ack.
- Assert `reset` asynchronously while in GRANT_CPU, with the ack arriving one cycle after reset release.
  - All outputs are 0 immediately.
  - The late ack is not forwarded to either requester.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-into-one mem_bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int STARVE_CNT_W = 4;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 16;
  localparam int MASK_W       = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_N64,
    GRANT_CPU
  } e_arb_state;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the N64 PI and MCU/USB requesters onto one mem_bus controller port.
// N64 wins ties until the CPU has been passed over STARVE_LIMIT times in a row.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              n64_request,
  input  logic              n64_write,
  input  logic [ADDR_W-1:0] n64_address,
  input  logic [DATA_W-1:0] n64_wdata,
  input  logic [MASK_W-1:0] n64_wmask,
  output logic              n64_ack,
  output logic [DATA_W-1:0] n64_rdata,

  input  logic              cpu_request,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [MASK_W-1:0] cpu_wmask,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  output logic              mem_request,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  e_arb_state              state, state_nxt;
  logic                    drop, drop_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_nxt;
  logic                    take_n64, take_cpu;

  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop;
    starve_nxt = starve_cnt;
    take_n64   = 1'b0;
    take_cpu   = 1'b0;
    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (n64_request && (!cpu_request || (starve_cnt < LIMIT_C))) begin
          take_n64 = 1'b1;
        end else if (cpu_request) begin
          take_cpu = 1'b1;
        end
        if (take_n64) begin
          state_nxt = GRANT_N64;
          if (cpu_request && (starve_cnt != '1)) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (take_cpu) begin
          state_nxt  = GRANT_CPU;
          starve_nxt = '0;
        end
        if (!cpu_request) begin
          starve_nxt = '0;
        end
      end
      GRANT_N64: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end else if (!n64_request) begin
          drop_nxt = 1'b1;
        end
      end
      GRANT_CPU: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end else if (!cpu_request) begin
          drop_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  // Output register bank: loaded from the winner on grant, held until the backend acks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      drop        <= 1'b0;
      starve_cnt  <= '0;
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
    end else begin
      state      <= state_nxt;
      drop       <= drop_nxt;
      starve_cnt <= starve_nxt;
      if (take_n64) begin
        mem_request <= 1'b1;
        mem_write   <= n64_write;
        mem_address <= n64_address;
        mem_wdata   <= n64_wdata;
        mem_wmask   <= n64_wmask;
      end else if (take_cpu) begin
        mem_request <= 1'b1;
        mem_write   <= cpu_write;
        mem_address <= cpu_address;
        mem_wdata   <= cpu_wdata;
        mem_wmask   <= cpu_wmask;
      end else if ((state != IDLE) && mem_ack) begin
        mem_request <= 1'b0;
      end
    end
  end

  // An abandoned transaction still completes on the backend, but its ack goes nowhere.
  always_comb begin
    n64_ack   = (state == GRANT_N64) && mem_ack && !drop;
    cpu_ack   = (state == GRANT_CPU) && mem_ack && !drop;
    n64_rdata = mem_rdata;
    cpu_rdata = mem_rdata;
    busy      = (state != IDLE);
  end

endmodule
